// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrix row fetch master.
//   ROW_W              width of one matrix row (one Avalon-MM read beat)
//   NUM_ROWS_DEFAULT   default number of rows fetched per transfer
//   state_t            fetch sequencer states
// -----------------------------------------------------------------------------
package matrix_pkg;

   localparam int ROW_W            = 64;
   localparam int NUM_ROWS_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DATA,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/matrix_fetch_master_row_buf.sv
// -----------------------------------------------------------------------------
// row_buf
// Local row storage for the fetch master: one synchronous write port and one
// asynchronous read port. Contents are not reset. Reads with an index at or
// beyond DEPTH return zero.
// Ports:
//   clk       clock
//   wr_en     write strobe
//   wr_addr   write row index
//   wr_data   row written
//   rd_addr   read row index
//   rd_data   mem[rd_addr], combinational
// -----------------------------------------------------------------------------
module row_buf #(
   parameter  int DEPTH = matrix_pkg::NUM_ROWS_DEFAULT,
   parameter  int WIDTH = matrix_pkg::ROW_W,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [31:0]      rd_addr_ext;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // compare at full width so non-power-of-two depths decode the hole
   assign rd_addr_ext = 32'(rd_addr);
   assign rd_data     = (rd_addr_ext < 32'(DEPTH)) ? mem[rd_addr] : '0;

endmodule

// File: rtl/matrix_fetch_master.sv
// -----------------------------------------------------------------------------
// matrix_fetch_master
// Avalon-MM read master that fetches NUM_ROWS consecutive 64-bit rows starting
// at word address BASE_ADDR into a local buffer, one outstanding read at a time.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for start
// REQ       | avm_read asserted with address BASE_ADDR+idx, waiting for accept
// WAIT_DATA | read accepted, waiting for readdatavalid of row idx
// DONE      | last row stored, done pulse for one cycle
// ERR       | watchdog expired, error set; returns to IDLE next cycle
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               single-cycle fetch request (honoured in IDLE only)
//   busy                high in REQ and WAIT_DATA
//   done                one-cycle pulse after the last row is stored
//   error               sticky watchdog flag, cleared by the next start
//   avm_*               Avalon-MM read master (word addressed)
//   row_sel, row_data   local buffer read port (combinational)
//
// Build option: define FETCH_TIMEOUT_EN to enable the per-phase watchdog of
// TIMEOUT_CYCLES cycles. Without it the master waits indefinitely and error
// is tied low.
// -----------------------------------------------------------------------------
module matrix_fetch_master
   import matrix_pkg::*;
#(
   parameter  int          NUM_ROWS       = NUM_ROWS_DEFAULT,
   parameter  logic [31:0] BASE_ADDR      = 32'd0,
   parameter  int          TIMEOUT_CYCLES = 64,
   localparam int          IDX_W          = $clog2(NUM_ROWS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [31:0]      avm_address,
   output logic             avm_read,
   input  logic             avm_waitrequest,
   input  logic [ROW_W-1:0] avm_readdata,
   input  logic             avm_readdatavalid,
   input  logic [IDX_W-1:0] row_sel,
   output logic [ROW_W-1:0] row_data
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROWS - 1);

   state_t           state, state_next;
   logic [IDX_W-1:0] idx, idx_next;
   logic             wr_en;
   logic             tmo;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         idx         <= '0;
         avm_read    <= 1'b0;
         avm_address <= '0;
      end else begin
         state       <= state_next;
         idx         <= idx_next;
         // registered from the next state so read/address stay stable in REQ
         avm_read    <= (state_next == REQ);
         avm_address <= BASE_ADDR + 32'(idx_next);
      end
   end

   always_comb begin
      state_next = state;
      idx_next   = idx;
      wr_en      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = REQ;
               idx_next   = '0;
            end
         end
         REQ: begin
            if (avm_read && !avm_waitrequest) begin
               state_next = WAIT_DATA;
            end else if (tmo) begin
               state_next = ERR;
            end
         end
         WAIT_DATA: begin
            if (avm_readdatavalid) begin
               wr_en = 1'b1;
               if (idx == LAST_IDX) begin
                  state_next = DONE;
               end else begin
                  idx_next   = idx + 1'b1;
                  state_next = REQ;
               end
            end else if (tmo) begin
               state_next = ERR;
            end
         end
         DONE:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == REQ) || (state == WAIT_DATA);
   assign done = (state == DONE);

`ifdef FETCH_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMR_W-1:0] tmr;
   logic             error_q;

   // down-counter reloaded on every state change, so each REQ or WAIT_DATA
   // phase gets a fresh TIMEOUT_CYCLES budget; expiry on the last cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmr <= '0;
      end else if (state_next != state) begin
         tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
      end else if (tmr != '0) begin
         tmr <= tmr - 1'b1;
      end
   end

   assign tmo = (tmr == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         error_q <= 1'b0;
      end else if (state_next == ERR) begin
         error_q <= 1'b1;
      end else if ((state == IDLE) && start) begin
         error_q <= 1'b0;
      end
   end

   assign error = error_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign tmo                = 1'b0;
   assign error              = 1'b0;
`endif

   row_buf #(
      .DEPTH (NUM_ROWS),
      .WIDTH (ROW_W)
   ) u_row_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (idx),
      .wr_data (avm_readdata),
      .rd_addr (row_sel),
      .rd_data (row_data)
   );

endmodule
